// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//
// Serial-in / parallel-out shift register with a word-holding register.
// Bits arrive on Din one per enabled clock. Every WIDTH accepted bits form a
// word. The completed word is copied into P, and word_valid pulses for one
// cycle.
//
// Parameters
//   WIDTH       register width in bits (2..32)
//   SHIFT_LEFT  1: new bit enters Q[0], data moves toward the MSB
//               0: new bit enters Q[WIDTH-1], data moves toward the LSB
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   rst_n       synchronous active-low reset
//   Din         serial data bit, sampled on the rising edge
//   en          shift enable, one bit is accepted per enabled edge
//   Q           live shift-register contents
//   P           last completed word, held between completions
//   word_valid  high for the one cycle after a word-completing edge
//   bit_cnt     number of bits accepted into the current word (0..WIDTH-1)
//
// Every output is a flop. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH      = 4,
    parameter int SHIFT_LEFT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Din,
    input  logic                     en,
    output logic [WIDTH-1:0]         Q,
    output logic [WIDTH-1:0]         P,
    output logic                     word_valid,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_next;
    logic             word_done;

    // The shift direction is fixed at elaboration, so only one form is built.
    generate
        if (SHIFT_LEFT != 0) begin : g_left
            assign q_next = {Q[WIDTH-2:0], Din};
        end else begin : g_right
            assign q_next = {Din, Q[WIDTH-1:1]};
        end
    endgenerate

    // The shift on this edge fills the last bit position of the current word.
    assign word_done = en && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q          <= '0;
            P          <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            // The pulse lasts one cycle. It is cleared on any edge that does
            // not complete a word, including edges where en is low.
            word_valid <= word_done;
            if (en) begin
                Q       <= q_next;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                // P captures the post-shift value so the word is already
                // complete when word_valid is seen.
                if (word_done) begin
                    P <= q_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_sipo_shift_reg
//
// Drives two instances with identical stimulus: one shifts left, one shifts
// right (WIDTH=4 in both). Each accepted bit is recorded. When four bits have
// been collected, the word each direction should present is pushed to its
// scoreboard queue. A queue entry is popped when that DUT raises word_valid.
// -----------------------------------------------------------------------------
module tb_sipo_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;

    logic [3:0] q_l, p_l, q_r, p_r;
    logic       wv_l, wv_r;
    logic [1:0] cnt_l, cnt_r;

    int         tests = 0;
    int         fails = 0;

    // Reference state: accepted bits of the current word, and expected words.
    logic       bits[$];
    logic [3:0] sb_l[$];
    logic [3:0] sb_r[$];
    logic [3:0] m_ql, m_qr, m_pl, m_pr;
    logic       m_wv;
    int         pulses_l, pulses_r;

    always #5 clk = ~clk;

    sipo_shift_reg #(.WIDTH(4), .SHIFT_LEFT(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .Din(din), .en(en),
        .Q(q_l), .P(p_l), .word_valid(wv_l), .bit_cnt(cnt_l)
    );

    sipo_shift_reg #(.WIDTH(4), .SHIFT_LEFT(0)) dut_r (
        .clk(clk), .rst_n(rst_n), .Din(din), .en(en),
        .Q(q_r), .P(p_r), .word_valid(wv_r), .bit_cnt(cnt_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across one rising edge. Then update the
    // reference and compare every output of both instances.
    task automatic step(input logic r, input logic e, input logic d);
        logic [3:0] w_l, w_r;
        @(negedge clk);
        rst_n = r;
        en    = e;
        din   = d;
        @(posedge clk);
        #1;
        m_wv = 1'b0;
        if (!r) begin
            m_ql = '0; m_qr = '0; m_pl = '0; m_pr = '0;
            bits.delete();
            sb_l.delete();
            sb_r.delete();
        end else if (e) begin
            m_ql = {m_ql[2:0], d};
            m_qr = {d, m_qr[3:1]};
            bits.push_back(d);
            if (bits.size() == 4) begin
                // Left shift: the first bit ends up in the MSB.
                // Right shift: the first bit ends up in the LSB.
                for (int i = 0; i < 4; i++) begin
                    w_l[3-i] = bits[i];
                    w_r[i]   = bits[i];
                end
                sb_l.push_back(w_l);
                sb_r.push_back(w_r);
                m_pl = w_l;
                m_pr = w_r;
                m_wv = 1'b1;
                bits.delete();
            end
        end
        chk("q_left",  q_l,  m_ql);
        chk("q_right", q_r,  m_qr);
        chk("p_left",  p_l,  m_pl);
        chk("p_right", p_r,  m_pr);
        chk("cnt_left",  cnt_l, bits.size());
        chk("cnt_right", cnt_r, bits.size());
        chk("wv_left",  wv_l, m_wv);
        chk("wv_right", wv_r, m_wv);
        if (wv_l === 1'b1) begin
            pulses_l++;
            chk("sb_left_nonempty", sb_l.size() > 0, 1);
            if (sb_l.size() > 0) chk("sb_left_word", p_l, sb_l.pop_front());
        end
        if (wv_r === 1'b1) begin
            pulses_r++;
            chk("sb_right_nonempty", sb_r.size() > 0, 1);
            if (sb_r.size() > 0) chk("sb_right_word", p_r, sb_r.pop_front());
        end
    endtask

    initial begin
        m_ql = '0; m_qr = '0; m_pl = '0; m_pr = '0; m_wv = 1'b0;
        pulses_l = 0; pulses_r = 0;

        // Reset state, with en and Din active to show they are ignored.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_q", q_l, 4'b0000);
        chk("rst_p", p_l, 4'b0000);
        chk("rst_wv", wv_l, 1'b0);
        chk("rst_cnt", cnt_l, 2'd0);

        // Left shift: Din 0,1,1,1.
        step(1'b1, 1'b1, 1'b0); chk("l_q0", q_l, 4'b0000);
        step(1'b1, 1'b1, 1'b1); chk("l_q1", q_l, 4'b0001);
        step(1'b1, 1'b1, 1'b1); chk("l_q2", q_l, 4'b0011);
        step(1'b1, 1'b1, 1'b1); chk("l_q3", q_l, 4'b0111);
        chk("l_word_p", p_l, 4'b0111);
        chk("l_word_wv", wv_l, 1'b1);
        chk("l_word_cnt", cnt_l, 2'd0);
        chk("r_word_p", p_r, 4'b1110);

        // Next bit: the pulse ends and P holds its value.
        step(1'b1, 1'b1, 1'b0);
        chk("l_next_q", q_l, 4'b1110);
        chk("l_next_wv", wv_l, 1'b0);
        chk("l_next_p", p_l, 4'b0111);
        chk("l_next_cnt", cnt_l, 2'd1);

        // Hold with en low while Din toggles.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("hold_q", q_l, 4'b1110);
        chk("hold_p", p_l, 4'b0111);
        chk("hold_cnt", cnt_l, 2'd1);
        chk("hold_wv", wv_l, 1'b0);

        // A rst_n glitch between edges must not disturb any output.
        #1 rst_n = 1'b0;
        #1;
        chk("glitch_q", q_l, 4'b1110);
        chk("glitch_p", p_l, 4'b0111);
        chk("glitch_cnt", cnt_l, 2'd1);
        rst_n = 1'b1;

        // Bring bit_cnt to 3, then reset on the edge that would complete a word.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_cnt", cnt_l, 2'd3);
        step(1'b0, 1'b1, 1'b1);
        chk("midword_rst_q", q_l, 4'b0000);
        chk("midword_rst_p", p_l, 4'b0000);
        chk("midword_rst_wv", wv_l, 1'b0);
        chk("midword_rst_cnt", cnt_l, 2'd0);

        // Right shift: Din 1,0,0,0 starts a new word after reset.
        step(1'b1, 1'b1, 1'b1); chk("r_q0", q_r, 4'b1000);
        step(1'b1, 1'b1, 1'b0); chk("r_q1", q_r, 4'b0100);
        step(1'b1, 1'b1, 1'b0); chk("r_q2", q_r, 4'b0010);
        step(1'b1, 1'b1, 1'b0); chk("r_q3", q_r, 4'b0001);
        chk("r_p", p_r, 4'b0001);
        chk("r_wv", wv_r, 1'b1);
        chk("l_p_1000", p_l, 4'b1000);

        // Forty enabled edges of random data from a clean reset.
        step(1'b0, 1'b0, 1'b0);
        pulses_l = 0;
        pulses_r = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        chk("rand_pulses_left", pulses_l, 10);
        chk("rand_pulses_right", pulses_r, 10);
        chk("rand_sb_left_empty", sb_l.size(), 0);
        chk("rand_sb_right_empty", sb_r.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_shift_reg.md
SIPO_SHIFT_REG -- requirements
Module: sipo_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter SHIFT_LEFT, default 1; 1 = new bit enters Q[0] and data moves toward the MSB; 0 = new bit enters Q[WIDTH-1] and data moves toward the LSB.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 Din  input  1  serial data bit, sampled on the rising clk edge.
REQ-006 en  input  1  shift enable; high = shift one bit this cycle.
REQ-007 Q  output  WIDTH  live shift-register contents, registered.
REQ-008 P  output  WIDTH  parallel word holding register, updated once per completed word.
REQ-009 word_valid  output  1  one-cycle pulse; high in the cycle P presents a newly completed word.
REQ-010 bit_cnt  output  clog2(WIDTH)  bits accepted into the current word, range 0..WIDTH-1.
REQ-011 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Function
REQ-012 A rising edge with rst_n=1 and en=1 SHALL shift exactly one bit.
  - SHIFT_LEFT=1: Q <= {Q[WIDTH-2:0], Din}.
  - SHIFT_LEFT=0: Q <= {Din, Q[WIDTH-1:1]}.
REQ-013 A rising edge with rst_n=1 and en=0 SHALL hold Q, P and bit_cnt, and SHALL drive word_valid to 0.
REQ-014 Each shift SHALL increment bit_cnt; when a shift occurs with bit_cnt=WIDTH-1, bit_cnt SHALL wrap to 0.
REQ-015 A shift with bit_cnt=WIDTH-1 completes a word. On that edge:
  - P SHALL load the post-shift value of Q.
  - word_valid SHALL be 1 for the following cycle.
REQ-016 Latency: Q reflects Din one clock after the sampling edge; P and word_valid change on the same edge that completes the word.
REQ-017 word_valid SHALL be 0 in every cycle not immediately following a word-completing edge; back-to-back words SHALL give one pulse every WIDTH enabled cycles.
REQ-018 P SHALL hold its value between word completions, regardless of en or Din activity.
REQ-019 Din and en values are don't-care while rst_n=0.

Reset
REQ-020 A rising edge with rst_n=0 SHALL set Q=0, P=0, bit_cnt=0 and word_valid=0, regardless of en and Din.
REQ-021 Reset SHALL take priority over shifting, including in the cycle that would complete a word; a partially accumulated word is discarded.
REQ-022 After rst_n returns high, the first enabled edge SHALL be treated as bit 0 of a new word.
REQ-023 rst_n SHALL act only on rising clk edges; a rst_n change between edges SHALL have no effect on any output.

Verification
REQ-024 WIDTH=4, SHIFT_LEFT=1, reset then en=1, Din=0,1,1,1 on four edges -> Q=0000,0001,0011,0111; after 4th edge P=0111, word_valid=1, bit_cnt=0.
REQ-025 Continue REQ-024 with Din=0 -> Q=1110, word_valid=0, P=0111, bit_cnt=1.
REQ-026 en=0 for 3 edges with Din toggling -> Q, P and bit_cnt unchanged; word_valid=0.
REQ-027 rst_n=0 on the edge where bit_cnt=3 and en=1 -> Q=0000, P=0000, word_valid=0, bit_cnt=0; no word pulse.
REQ-028 SHIFT_LEFT=0, WIDTH=4, Din=1,0,0,0 -> Q=1000,0100,0010,0001; P=0001 with word_valid pulse after 4th edge.
REQ-029 Continuous en=1 with random Din for 40 edges -> exactly 10 word_valid pulses, each P equal to the last 4 Din bits in shift order.
